sbqm_queue_ctrl: RTL

//   Parametrised, clocked successor to the bank-queue manager. Synchronises the

---
 rtl/sbqm_queue_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sbqm_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sbqm_queue_ctrl
// Description : Bank-queue manager with synchronised gate sensors, saturating
//               people counter and a multi-cycle restoring-divider wait estimate.
// Revision    : 1.0 - initial release
// ============================================================================
module sbqm_queue_ctrl #(
    parameter int MAX_PEOPLE = 7,
    parameter int TELLER_W   = 2,
    parameter int SERVICE_T  = 3,
    parameter int WAIT_W     = 5,
    localparam int CNT_W     = $clog2(MAX_PEOPLE + 1),
    localparam int NUM_W     = $clog2(SERVICE_T * (MAX_PEOPLE + 2**TELLER_W - 2) + 1)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                SenseIn,
    input  logic                SenseOut,
    input  logic [TELLER_W-1:0] TellerCount,
    output logic [CNT_W-1:0]    PeopleCount,
    output logic                FullFlag,
    output logic                EmptyFlag,
    output logic                RejectIn,
    output logic                RejectOut,
    output logic [WAIT_W-1:0]   WaitTime,
    output logic                WaitValid
);

    localparam int STEP_W = $clog2(NUM_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic                r_syncIn1, r_syncIn2, r_prevIn;
    logic                r_syncOut1, r_syncOut2, r_prevOut;
    logic [TELLER_W-1:0] r_tellerReg;
    logic [CNT_W-1:0]    r_count;
    logic                r_rejectIn, r_rejectOut;

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_opCount;
    logic [TELLER_W-1:0] r_opTeller;
    logic [NUM_W-1:0]    r_num;
    logic [NUM_W-1:0]    r_quo;
    logic [TELLER_W-1:0] r_rem;
    logic [STEP_W-1:0]   r_step;
    logic [WAIT_W-1:0]   r_waitTime;
    logic                r_waitValid;

    logic                w_inc, w_dec, w_full, w_empty, w_opChange;
    logic [NUM_W-1:0]    w_sum, w_num;
    logic [TELLER_W:0]   w_trial;
    logic                w_geq;
    logic [TELLER_W-1:0] w_diff;
    logic [WAIT_W-1:0]   w_quoSat, w_result;

    assign w_inc      = r_syncIn2 & ~r_prevIn;
    assign w_dec      = r_syncOut2 & ~r_prevOut;
    assign w_full     = (r_count == CNT_W'(MAX_PEOPLE));
    assign w_empty    = (r_count == '0);
    assign w_opChange = ({r_count, r_tellerReg} != {r_opCount, r_opTeller});

    // Numerator only matters when both operands are non-zero; it then fits NUM_W.
    assign w_sum = NUM_W'(r_opCount) + NUM_W'(r_opTeller) - NUM_W'(1);
    assign w_num = NUM_W'(SERVICE_T) * w_sum;

    assign w_trial = {r_rem, r_num[NUM_W-1]};
    assign w_geq   = (w_trial >= {1'b0, r_opTeller});
    assign w_diff  = w_trial[TELLER_W-1:0] - r_opTeller;

    generate
        if (NUM_W > WAIT_W) begin : g_sat
            assign w_quoSat = (|r_quo[NUM_W-1:WAIT_W]) ? {WAIT_W{1'b1}} : r_quo[WAIT_W-1:0];
        end else begin : g_noSat
            assign w_quoSat = WAIT_W'(r_quo);
        end
    endgenerate

    assign w_result = (r_opCount == '0)  ? '0 :
                      (r_opTeller == '0) ? {WAIT_W{1'b1}} : w_quoSat;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_syncIn1   <= 1'b0;
            r_syncIn2   <= 1'b0;
            r_prevIn    <= 1'b0;
            r_syncOut1  <= 1'b0;
            r_syncOut2  <= 1'b0;
            r_prevOut   <= 1'b0;
            r_tellerReg <= '0;
            r_count     <= '0;
            r_rejectIn  <= 1'b0;
            r_rejectOut <= 1'b0;
            r_state     <= S_IDLE;
            r_opCount   <= '0;
            r_opTeller  <= '0;
            r_num       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_step      <= '0;
            r_waitTime  <= '0;
            r_waitValid <= 1'b1;
        end else begin
            r_syncIn1   <= SenseIn;
            r_syncIn2   <= r_syncIn1;
            r_prevIn    <= r_syncIn2;
            r_syncOut1  <= SenseOut;
            r_syncOut2  <= r_syncOut1;
            r_prevOut   <= r_syncOut2;
            r_tellerReg <= TellerCount;
            r_rejectIn  <= 1'b0;
            r_rejectOut <= 1'b0;

            if (w_inc && !w_dec) begin
                if (w_full) r_rejectIn <= 1'b1;
                else        r_count    <= r_count + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
                if (w_empty) r_rejectOut <= 1'b1;
                else         r_count     <= r_count - CNT_W'(1);
            end

            // Any operand change outside IDLE abandons the division in flight.
            if (r_state != S_IDLE && w_opChange) begin
                r_state    <= S_LOAD;
                r_opCount  <= r_count;
                r_opTeller <= r_tellerReg;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_opChange) begin
                            r_state     <= S_LOAD;
                            r_opCount   <= r_count;
                            r_opTeller  <= r_tellerReg;
                            r_waitValid <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        r_num   <= w_num;
                        r_quo   <= '0;
                        r_rem   <= '0;
                        r_step  <= '0;
                        r_state <= S_DIV;
                    end
                    S_DIV: begin
                        r_rem  <= w_geq ? w_diff : w_trial[TELLER_W-1:0];
                        r_quo  <= {r_quo[NUM_W-2:0], w_geq};
                        r_num  <= {r_num[NUM_W-2:0], 1'b0};
                        r_step <= r_step + STEP_W'(1);
                        if (r_step == STEP_W'(NUM_W - 1)) r_state <= S_DONE;
                    end
                    S_DONE: begin
                        r_waitTime  <= w_result;
                        r_waitValid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign PeopleCount = r_count;
    assign FullFlag    = w_full;
    assign EmptyFlag   = w_empty;
    assign RejectIn    = r_rejectIn;
    assign RejectOut   = r_rejectOut;
    assign WaitTime    = r_waitTime;
    assign WaitValid   = r_waitValid;

endmodule
`default_nettype wire
